// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/freeze control for the segmented RISC-V core
// Handles load-use stalls, taken-branch flushes and data-memory freezes, with saturating counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             DMRd_ex,
  input  logic             NextPCSrc_ex,
  input  logic             DMReq_me,
  input  logic             DMReady,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_en,
  output logic             idex_clr,
  output logic             exme_en,
  output logic             mewb_en,
  output logic             mewb_clr,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            lu, mb, timeout, freeze, flush, stall;

  always_comb begin
    lu = DMRd_ex && (rd_ex != 5'd0) &&
         ((use_rs1_id && (rs1_id == rd_ex)) || (use_rs2_id && (rs2_id == rd_ex)));
    mb = DMReq_me && !DMReady;
    timeout = (state == MEM_WAIT) && !DMReady && (wait_cnt == WC_W'(MEM_TIMEOUT));
    // Release and timeout cycles fall through to the RUN priority rules with mb masked.
    freeze = (state == RUN) ? mb : (!DMReady && !timeout);
    flush  = !freeze && NextPCSrc_ex;
    stall  = !freeze && !NextPCSrc_ex && lu;
  end

  always_comb begin
    if (rst) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      ifid_clr = 1'b1;
      idex_en  = 1'b0;
      idex_clr = 1'b1;
      exme_en  = 1'b0;
      mewb_en  = 1'b0;
      mewb_clr = 1'b1;
    end else begin
      pc_en    = !(freeze || stall);
      ifid_en  = !(freeze || stall);
      ifid_clr = flush;
      idex_en  = !freeze;
      idex_clr = flush || stall;
      exme_en  = !freeze;
      mewb_en  = !freeze;
      mewb_clr = freeze;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mb) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (freeze) begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
            if (timeout) mem_err <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
      if (!pc_en && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic use_rs1_id, use_rs2_id, DMRd_ex, NextPCSrc_ex, DMReq_me, DMReady;
  logic pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exme_en, mewb_en, mewb_clr, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit m_wait;
  int m_waited;
  bit m_err;
  int m_stall, m_flush;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .DMRd_ex(DMRd_ex), .NextPCSrc_ex(NextPCSrc_ex),
    .DMReq_me(DMReq_me), .DMReady(DMReady),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr), .idex_en(idex_en),
    .idex_clr(idex_clr), .exme_en(exme_en), .mewb_en(mewb_en), .mewb_clr(mewb_clr),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int outs();
    return {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exme_en, mewb_en, mewb_clr};
  endfunction

  task automatic model_reset();
    m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic idle_inputs();
    rs1_id = 0; rs2_id = 0; rd_ex = 0; use_rs1_id = 0; use_rs2_id = 0;
    DMRd_ex = 0; NextPCSrc_ex = 0; DMReq_me = 0; DMReady = 1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_stall_cnt"}, int'(stall_cnt), m_stall);
    check({tag, "_flush_cnt"}, int'(flush_cnt), m_flush);
    check({tag, "_mem_err"}, int'(mem_err), int'(m_err));
  endtask

  // Async reset asserted between clock edges; values must clear without an edge.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check({tag, "_rst_outs"}, outs(), 8'b0010_1001);
    check_state({tag, "_rst"});
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle: apply inputs, check Mealy outputs, clock, check registered state.
  task automatic step(input string tag, input bit ld, input int rd, input int r1, input int r2,
                      input bit u1, input bit u2, input bit br, input bit req, input bit rdy);
    bit lu, frz, tmo;
    int kind;
    int exp_o;
    @(negedge clk);
    DMRd_ex = ld; rd_ex = 5'(rd); rs1_id = 5'(r1); rs2_id = 5'(r2);
    use_rs1_id = u1; use_rs2_id = u2; NextPCSrc_ex = br; DMReq_me = req; DMReady = rdy;
    #1;
    lu = ld && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
    if (!m_wait) begin
      tmo = 0;
      frz = req && !rdy;
    end else begin
      tmo = !rdy && m_waited == TO;
      frz = !rdy && !tmo;
    end
    // kind: 0 run, 1 freeze, 2 flush, 3 load-use stall
    if (frz) kind = 1;
    else if (br) kind = 2;
    else if (lu) kind = 3;
    else kind = 0;
    case (kind)
      1:       exp_o = 8'b0000_0001;
      2:       exp_o = 8'b1111_1110;
      3:       exp_o = 8'b0001_1110;
      default: exp_o = 8'b1101_0110;
    endcase
    check({tag, "_outs"}, outs(), exp_o);
    @(posedge clk);
    if (frz) begin
      if (!m_wait) begin m_wait = 1; m_waited = 1; end
      else m_waited++;
    end else begin
      m_wait = 0; m_waited = 0;
      if (tmo) m_err = 1;
    end
    if ((kind == 1 || kind == 3) && m_stall < CMAX) m_stall++;
    if (kind == 2 && m_flush < CMAX) m_flush++;
    #1;
    check_state(tag);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    model_reset();
    do_reset("init");

    // load-use on rs1
    step("lu", 1, 5, 5, 0, 1, 0, 0, 0, 1);
    check("lu_cnt", int'(stall_cnt), 1);
    step("lu_after", 0, 5, 5, 0, 1, 0, 0, 0, 1);
    // x0 and non-load never stall
    step("x0", 1, 0, 0, 0, 1, 1, 0, 0, 1);
    step("noload", 0, 7, 0, 7, 0, 1, 0, 0, 1);
    check("nostall_cnt", int'(stall_cnt), 1);

    do_reset("br");
    step("br_lu", 1, 9, 9, 9, 1, 1, 1, 0, 1);
    check("br_flush", int'(flush_cnt), 1);
    check("br_stall", int'(stall_cnt), 0);

    // memory wait: ready low for 3 cycles, then release with a held branch
    do_reset("mw");
    for (int i = 0; i < 3; i++) step("mw_wait", 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("mw_rel", 0, 0, 0, 0, 0, 0, 1, 1, 1);
    check("mw_stall", int'(stall_cnt), 3);

    // timeout abandons the access; mem_err sticky
    do_reset("to");
    for (int i = 0; i < TO + 1; i++) step("to_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("to_err", int'(mem_err), 1);
    for (int i = 0; i < 3; i++) step("to_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("to_sticky", int'(mem_err), 1);

    // reset in the middle of a wait
    step("rw_a", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("rw_b", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    do_reset("rw");
    step("rw_post", 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // saturation
    for (int i = 0; i < 20; i++) step("sat_s", 1, 3, 0, 3, 0, 1, 0, 0, 1);
    check("sat_stall", int'(stall_cnt), CMAX);
    for (int i = 0; i < 20; i++) step("sat_f", 0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("sat_flush", int'(flush_cnt), CMAX);

    // randomized
    do_reset("rnd");
    for (int i = 0; i < 1500; i++) begin
      int rd, r1, r2;
      bit req, rdy;
      rd = $urandom_range(0, 3);
      r1 = $urandom_range(0, 3);
      r2 = $urandom_range(0, 3);
      req = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0) || ($urandom_range(0, 99) < 5 && m_waited > 0 && 0);
      if (m_wait && $urandom_range(0, 3) != 0) rdy = 0;
      step("rnd", 1'($urandom_range(0, 1)), rd, r1, r2, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), req, rdy);
      if ($urandom_range(0, 59) == 0) do_reset("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
